// File: rtl/brent_kung_sub8_pipe.sv
// Three-stage pipelined 8-bit add/subtract on a Brent-Kung prefix network,
// with a valid/ready handshake on both sides and carry, overflow and zero flags.
module brent_kung_sub8_pipe #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_d,
  output logic             out_cout,
  output logic             out_ovf,
  output logic             out_zero
);

  logic ready1, ready2, ready3;
  logic v1, v2;

  // An empty stage never blocks; a full one passes ready down from its successor.
  assign ready3   = !out_valid || out_ready;
  assign ready2   = !v2 || ready3;
  assign ready1   = !v1 || ready2;
  assign in_ready = ready1;

  // ---------------- Stage 1: generate / propagate ----------------
  logic [WIDTH-1:0] b_eff, p0, g0, g0_fold;

  always_comb begin
    b_eff   = in_b ^ {WIDTH{in_sub}};
    p0      = in_a ^ b_eff;
    g0      = in_a & b_eff;
    g0_fold = {g0[7:1], g0[0] | (p0[0] & in_sub)};
  end

  logic [WIDTH-1:0] s1_p, s1_g;
  logic             s1_cin;

  // NOTE: sequential state uses non-blocking assignments so every stage samples
  // the values its predecessor held before this edge.
  always_ff @(posedge clk) begin
    if (rst) v1 <= 1'b0;
    else if (ready1) v1 <= in_valid;
  end

  // NOTE: pipeline data registers carry no reset; they are qualified by the
  // valid bits, which are reset, so stale contents are never observed.
  always_ff @(posedge clk) begin
    if (ready1 && in_valid) begin
      s1_p   <= p0;
      s1_g   <= g0_fold;
      s1_cin <= in_sub;
    end
  end

  // ---------------- Stage 2: up-sweep black cells ----------------
  logic g10, g32, p32, g54, p54, g76, p76, g30, g74, p74;

  always_comb begin
    g10 = s1_g[1] | (s1_p[1] & s1_g[0]);
    g32 = s1_g[3] | (s1_p[3] & s1_g[2]);
    p32 = s1_p[3] & s1_p[2];
    g54 = s1_g[5] | (s1_p[5] & s1_g[4]);
    p54 = s1_p[5] & s1_p[4];
    g76 = s1_g[7] | (s1_p[7] & s1_g[6]);
    p76 = s1_p[7] & s1_p[6];
    g30 = g32 | (p32 & g10);
    g74 = g76 | (p76 & g54);
    p74 = p76 & p54;
  end

  logic [WIDTH-1:0] s2_p;
  logic [3:0]       s2_g;   // single-bit generates {g6, g4, g2, G0}
  logic             s2_g10, s2_g30, s2_g54, s2_p54, s2_g74, s2_p74, s2_cin;

  always_ff @(posedge clk) begin
    if (rst) v2 <= 1'b0;
    else if (ready2) v2 <= v1;
  end

  always_ff @(posedge clk) begin
    if (ready2 && v1) begin
      s2_p   <= s1_p;
      s2_g   <= {s1_g[6], s1_g[4], s1_g[2], s1_g[0]};
      s2_g10 <= g10;
      s2_g30 <= g30;
      s2_g54 <= g54;
      s2_p54 <= p54;
      s2_g74 <= g74;
      s2_p74 <= p74;
      s2_cin <= s1_cin;
    end
  end

  // ---------------- Stage 3: down-sweep gray cells and sum ----------------
  logic [WIDTH:0]   c;
  logic [WIDTH-1:0] d;

  always_comb begin
    c[0] = s2_cin;
    c[1] = s2_g[0];
    c[2] = s2_g10;
    c[4] = s2_g30;
    c[3] = s2_g[1] | (s2_p[2] & c[2]);
    c[6] = s2_g54  | (s2_p54  & c[4]);
    c[5] = s2_g[2] | (s2_p[4] & c[4]);
    c[7] = s2_g[3] | (s2_p[6] & c[6]);
    c[8] = s2_g74  | (s2_p74  & c[4]);
    d    = s2_p ^ c[WIDTH-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_d     <= '0;
      out_cout  <= 1'b0;
      out_ovf   <= 1'b0;
      out_zero  <= 1'b0;
    end else if (ready3) begin
      out_valid <= v2;
      if (v2) begin
        out_d    <= d;
        out_cout <= c[8];
        out_ovf  <= c[8] ^ c[7];
        out_zero <= (d == '0);
      end
    end
  end

endmodule
